pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and sequencing controller for the pipelined core.
- Tracks in-flight register writes over DEPTH post-decode stages.
- Generates operand-forwarding selects, load-use stalls and branch flushes.
- Runs an interrupt drain/acknowledge state machine.
- Sits beside the decode stage and drives the stall/flush inputs of the fetch stage, IF/ID buffer and ID/EX buffer.

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request / hazard-control response bundle for pipe_hazard_ctrl.
// With HAZARD_STATS_EN defined the bundle also carries the stall/flush statistic counters.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1_addr;
    logic                  id_src1_used;
    logic [REG_ADDR_W-1:0] id_src2_addr;
    logic                  id_src2_used;
    logic [REG_ADDR_W-1:0] id_dst_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  branch_taken;
    logic                  interrupt;

    logic                  stall_if;
    logic                  stall_id;
    logic                  flush_if_id;
    logic                  bubble_id_ex;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic                  int_active;
    logic                  int_ack;
`ifdef HAZARD_STATS_EN
    logic [15:0]           stall_count;
    logic [15:0]           flush_count;
`endif

    modport master (
        output id_valid, id_src1_addr, id_src1_used, id_src2_addr, id_src2_used,
        output id_dst_addr, id_reg_write, id_mem_read, branch_taken, interrupt,
        input  stall_if, stall_id, flush_if_id, bubble_id_ex,
        input  fwd_sel1, fwd_sel2, int_active, int_ack
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  id_valid, id_src1_addr, id_src1_used, id_src2_addr, id_src2_used,
        input  id_dst_addr, id_reg_write, id_mem_read, branch_taken, interrupt,
        output stall_if, stall_id, flush_if_id, bubble_id_ex,
        output fwd_sel1, fwd_sel2, int_active, int_ack
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: in-flight write scoreboard, forwarding, load-use stall,
// branch flush and interrupt drain/ack FSM. HAZARD_STATS_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int INT_HOLD   = 2
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam logic [3:0] HOLD_INIT = 4'(INT_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SAVE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Stage k of the scoreboard holds the instruction k cycles past decode.
    logic                  ent_valid_r [1:DEPTH];
    logic [REG_ADDR_W-1:0] ent_dst_r   [1:DEPTH];
    logic                  ent_wr_r    [1:DEPTH];
    logic                  ent_ld_r    [1:DEPTH];

    state_t     state_r;
    logic       pending_r;
    logic       int_q_r;
    logic [3:0] hold_cnt_r;
    logic       int_active_r;
    logic       int_ack_r;

    logic [SEL_W-1:0] fwd1_raw_s;
    logic [SEL_W-1:0] fwd2_raw_s;
    logic             ld_hit1_s;
    logic             ld_hit2_s;
    logic             load_use_s;
    logic             drain_s;
    logic             empty_s;
    logic             bubble_s;
    logic             flush_s;
    logic             edge_s;

    // Forwarding match (youngest stage wins), load-use detection and scoreboard-empty flag
    always_comb begin
        fwd1_raw_s = '0;
        fwd2_raw_s = '0;
        empty_s    = 1'b1;
        for (int k = DEPTH; k >= 1; k--) begin
            fwd1_raw_s = (bus.id_src1_used && ent_valid_r[k] && ent_wr_r[k] &&
                          (ent_dst_r[k] == bus.id_src1_addr)) ? SEL_W'(k) : fwd1_raw_s;
            fwd2_raw_s = (bus.id_src2_used && ent_valid_r[k] && ent_wr_r[k] &&
                          (ent_dst_r[k] == bus.id_src2_addr)) ? SEL_W'(k) : fwd2_raw_s;
            empty_s    = empty_s & ~ent_valid_r[k];
        end
        ld_hit1_s = bus.id_src1_used && ent_valid_r[1] && ent_wr_r[1] && ent_ld_r[1] &&
                    (ent_dst_r[1] == bus.id_src1_addr);
        ld_hit2_s = bus.id_src2_used && ent_valid_r[1] && ent_wr_r[1] && ent_ld_r[1] &&
                    (ent_dst_r[1] == bus.id_src2_addr);
    end

    assign load_use_s = ld_hit1_s | ld_hit2_s;
    assign drain_s    = (state_r == ST_DRAIN);
    assign bubble_s   = load_use_s | drain_s;
    // A stalled branch is re-presented next cycle; outside IDLE branches are ignored.
    assign flush_s    = bus.branch_taken & ~load_use_s & (state_r == ST_IDLE);
    assign edge_s     = bus.interrupt & ~int_q_r;

    assign bus.stall_if     = bubble_s | (state_r == ST_HOLD);
    assign bus.stall_id     = bubble_s;
    assign bus.bubble_id_ex = bubble_s;
    assign bus.flush_if_id  = flush_s;
    assign bus.fwd_sel1     = ld_hit1_s ? '0 : fwd1_raw_s;
    assign bus.fwd_sel2     = ld_hit2_s ? '0 : fwd2_raw_s;
    assign bus.int_active   = int_active_r;
    assign bus.int_ack      = int_ack_r;

    // Scoreboard shift: decode enters stage 1 unless bubbled, older entries advance
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_valid_r[k] <= 1'b0;
                ent_dst_r[k]   <= '0;
                ent_wr_r[k]    <= 1'b0;
                ent_ld_r[k]    <= 1'b0;
            end
        end else begin
            ent_valid_r[1] <= bus.id_valid & ~bubble_s;
            ent_dst_r[1]   <= bus.id_dst_addr;
            ent_wr_r[1]    <= bus.id_reg_write;
            ent_ld_r[1]    <= bus.id_mem_read;
            for (int k = 2; k <= DEPTH; k++) begin
                ent_valid_r[k] <= ent_valid_r[k-1];
                ent_dst_r[k]   <= ent_dst_r[k-1];
                ent_wr_r[k]    <= ent_wr_r[k-1];
                ent_ld_r[k]    <= ent_ld_r[k-1];
            end
        end
    end

    // Interrupt FSM: edge capture, drain, one-cycle ack, vector-load hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pending_r    <= 1'b0;
            int_q_r      <= 1'b0;
            hold_cnt_r   <= 4'd0;
            int_active_r <= 1'b0;
            int_ack_r    <= 1'b0;
        end else begin
            int_q_r <= bus.interrupt;
            case (state_r)
                ST_IDLE: begin
                    pending_r <= pending_r | edge_s;
                    int_ack_r <= 1'b0;
                    if (pending_r | edge_s) begin
                        state_r      <= ST_DRAIN;
                        int_active_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        int_active_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    pending_r    <= pending_r | edge_s;
                    int_active_r <= 1'b1;
                    if (empty_s) begin
                        state_r   <= ST_SAVE;
                        int_ack_r <= 1'b1;
                    end else begin
                        state_r   <= ST_DRAIN;
                        int_ack_r <= 1'b0;
                    end
                end
                ST_SAVE: begin
                    // A fresh edge in the ack cycle is a new request, so it survives the clear.
                    pending_r    <= edge_s;
                    state_r      <= ST_HOLD;
                    hold_cnt_r   <= HOLD_INIT;
                    int_active_r <= 1'b1;
                    int_ack_r    <= 1'b0;
                end
                ST_HOLD: begin
                    pending_r <= pending_r | edge_s;
                    int_ack_r <= 1'b0;
                    if (hold_cnt_r == 4'd0) begin
                        state_r      <= ST_IDLE;
                        int_active_r <= 1'b0;
                    end else begin
                        hold_cnt_r   <= hold_cnt_r - 4'd1;
                        int_active_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pending_r    <= 1'b0;
                    hold_cnt_r   <= 4'd0;
                    int_active_r <= 1'b0;
                    int_ack_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating load-use stall and branch flush counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (load_use_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.stall_count = stall_cnt_r;
    assign bus.flush_count = flush_cnt_r;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3, INT_HOLD=2); expected output vectors are queued
// per cycle and compared against the DUT. HAZARD_STATS_EN enables the counter checks.
module tb_pipe_hazard_ctrl;
    localparam int REG_ADDR_W = 4;
    localparam int DEPTH      = 3;
    localparam int INT_HOLD   = 2;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   checks;
    int   failures;
    logic [9:0] obs;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) bus ();

    pipe_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .INT_HOLD(INT_HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, flush_if_id, bubble_id_ex, fwd_sel1, fwd_sel2, int_active, int_ack}
    function automatic logic [9:0] E(input logic si, input logic sd, input logic fl, input logic bb,
                                     input logic [1:0] f1, input logic [1:0] f2,
                                     input logic ia, input logic ik);
        return {si, sd, fl, bb, f1, f2, ia, ik};
    endfunction

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2,
                          input logic [3:0] dst, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_src1_addr = s1;
        bus.id_src1_used = u1;
        bus.id_src2_addr = s2;
        bus.id_src2_used = u2;
        bus.id_dst_addr  = dst;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic step(input string tag, input logic [9:0] expv);
        exp_t e;
        q.push_back('{tag: tag, val: expv});
        #2;
        e   = q.pop_front();
        obs = {bus.stall_if, bus.stall_id, bus.flush_if_id, bus.bubble_id_ex,
               bus.fwd_sel1, bus.fwd_sel2, bus.int_active, bus.int_ack};
        checks++;
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
        end
        @(negedge clk);
    endtask

    localparam logic [9:0] ZERO  = 10'd0;
    localparam logic [9:0] STALL = 10'b1101_00_00_0_0;
    localparam logic [9:0] DRN   = 10'b1101_00_00_1_0;
    localparam logic [9:0] ACK   = 10'b0000_00_00_1_1;
    localparam logic [9:0] HLD   = 10'b1000_00_00_1_0;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.branch_taken = 1'b0;
        bus.interrupt = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        step("reset", ZERO);
        reset = 1'b0;

        // forwarding distance for a plain write to R3
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0); step("t1_wr", ZERO);
        set_id(1'b1, 4'd3, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0); step("t1_s1", E(0,0,0,0,2'd1,2'd0,0,0));
        step("t1_s2", E(0,0,0,0,2'd2,2'd0,0,0));
        set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0); step("t1_s3", E(0,0,0,0,2'd3,2'd3,0,0));
        step("t1_s4", ZERO);

        // youngest writer wins; unused source never forwards
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0); step("pri_w1", ZERO);
        step("pri_w2", ZERO);
        set_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("pri_rd", E(0,0,0,0,2'd1,2'd0,0,0));
        set_id(1'b1, 4'd4, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0); step("pri_unused", ZERO);

        // load-use on src1, then on src2
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1); step("lu_ld", ZERO);
        set_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("lu_stall", STALL);
        step("lu_fwd2", E(0,0,0,0,2'd2,2'd0,0,0));
        step("lu_fwd3", E(0,0,0,0,2'd3,2'd0,0,0));
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1); step("lu2_ld", ZERO);
        set_id(1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0); step("lu2_stall", STALL);
        step("lu2_fwd", E(0,0,0,0,2'd0,2'd2,0,0));

        // branch flush without hazard; branch instruction itself writes nothing
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0); step("br_wr", ZERO);
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        bus.branch_taken = 1'b1; step("br_flush", E(0,0,1,0,2'd0,2'd0,0,0));
        bus.branch_taken = 1'b0;
        set_id(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("br_next", E(0,0,0,0,2'd2,2'd0,0,0));

        // stall beats branch, branch retried next cycle
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1); step("bl_ld", ZERO);
        set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        bus.branch_taken = 1'b1; step("bl_stall", STALL);
        step("bl_flush", E(0,0,1,0,2'd2,2'd0,0,0));
        bus.branch_taken = 1'b0;

        // interrupt with full pipeline, second edge in HOLD, merged edge in DRAIN
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
        step("int_fill1", ZERO); step("int_fill2", ZERO); step("int_fill3", ZERO);
        bus.interrupt = 1'b1; step("int_t0", ZERO);
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("int_t1", DRN);
        bus.branch_taken = 1'b1; step("int_t2_br", DRN);
        bus.branch_taken = 1'b0; bus.interrupt = 1'b0; step("int_t3", DRN);
        step("int_t4", DRN);
        step("int_t5_ack", ACK);
        bus.interrupt = 1'b1; step("int_t6_hold", HLD);
        step("int_t7_hold", HLD);
        bus.interrupt = 1'b0; step("int_t8_idle", ZERO);
        bus.interrupt = 1'b1; step("int_t9_drain", DRN);
        step("int_t10_ack", ACK);
        step("int_t11_hold", HLD); step("int_t12_hold", HLD);
        step("int_t13_idle", ZERO); step("int_t14_idle", ZERO);

        // reset in DRAIN aborts the sequence and clears the scoreboard
        bus.interrupt = 1'b0;
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
        step("rs_fill1", ZERO); step("rs_fill2", ZERO);
        bus.interrupt = 1'b1; step("rs_edge", ZERO);
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("rs_drain", DRN);
        reset = 1'b1; bus.interrupt = 1'b0; step("rs_during", DRN);
        reset = 1'b0;
        set_id(1'b1, 4'd14, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("rs_after", ZERO);
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("rs_idle1", ZERO); step("rs_idle2", ZERO); step("rs_idle3", ZERO); step("rs_idle4", ZERO);

`ifdef HAZARD_STATS_EN
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1); step("st_ld", ZERO);
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("st_stall", STALL);
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); step("st_idle", ZERO);
        checks++;
        assert (bus.stall_count === 16'd1) else begin
            failures++;
            $error("FAIL stall_count observed=%0d expected=1", bus.stall_count);
        end
        bus.branch_taken = 1'b1;
        repeat (65540) @(negedge clk);
        bus.branch_taken = 1'b0;
        #2;
        checks++;
        assert (bus.flush_count === 16'hFFFF) else begin
            failures++;
            $error("FAIL flush_sat observed=%h expected=ffff", bus.flush_count);
        end
        checks++;
        assert (bus.stall_count === 16'd1) else begin
            failures++;
            $error("FAIL stall_hold observed=%0d expected=1", bus.stall_count);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
